// File: rtl/rfi_acc_sequencer_if.sv
// Bus bundle for the RFI accumulation sequencer.
//   master : run-control source (arm/stop/acc_len/sync_in/din_valid/sync_err_clr),
//            sink of sequencer status and sample tags.
//   slave  : the sequencer itself.
// Outputs: valid_out, new_acc, chan_idx, acc_done, acc_cnt, busy, sync_err, acc_timestamp.
interface rfi_acc_sequencer_if #(
  parameter int unsigned CHANNEL_ADDR  = 9,
  parameter int unsigned ACC_CNT_WIDTH = 32
);
  logic                     arm;
  logic                     stop;
  logic [31:0]              acc_len;
  logic                     sync_in;
  logic                     din_valid;
  logic                     sync_err_clr;
  logic                     valid_out;
  logic                     new_acc;
  logic [CHANNEL_ADDR-1:0]  chan_idx;
  logic                     acc_done;
  logic [ACC_CNT_WIDTH-1:0] acc_cnt;
  logic                     busy;
  logic                     sync_err;
  logic [31:0]              acc_timestamp;

  modport master (
    output arm, stop, acc_len, sync_in, din_valid, sync_err_clr,
    input  valid_out, new_acc, chan_idx, acc_done, acc_cnt, busy, sync_err, acc_timestamp
  );

  modport slave (
    input  arm, stop, acc_len, sync_in, din_valid, sync_err_clr,
    output valid_out, new_acc, chan_idx, acc_done, acc_cnt, busy, sync_err, acc_timestamp
  );
endinterface

// File: rtl/rfi_acc_sequencer.sv
// Run-control sequencer for the RFI power datapath.
// Arms on request, aligns to the spectrum sync, counts channels/spectra per
// accumulation and tags each sample with new_acc / chan_idx / acc_done.
// acc_len is only taken at accumulation boundaries (0 is treated as 1).
// Ports: clk, rst_n (async active-low), bus (rfi_acc_sequencer_if.slave).
// Optional: define RFI_ACC_TIMESTAMP_EN to capture a free-running cycle
// counter into acc_timestamp whenever new_acc is asserted; otherwise 0.
module rfi_acc_sequencer #(
  parameter int unsigned CHANNEL_ADDR  = 9,
  parameter int unsigned ACC_CNT_WIDTH = 32
) (
  input logic                clk,
  input logic                rst_n,
  rfi_acc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_SYNC, RUN, DRAIN} state_e;

  localparam logic [CHANNEL_ADDR-1:0] CHAN_MAX = '1;

  state_e                   state_q, state_d;
  logic [CHANNEL_ADDR-1:0]  chan_cnt_q, chan_cnt_d;
  logic [31:0]              spec_cnt_q, spec_cnt_d;
  logic [31:0]              len_q, len_d;
  logic [ACC_CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
  logic [CHANNEL_ADDR-1:0]  chan_idx_q, chan_idx_d;
  logic                     valid_out_q, valid_out_d;
  logic                     new_acc_q, new_acc_d;
  logic                     acc_done_q, acc_done_d;
  logic                     busy_q, busy_d;
  logic                     sync_err_q, sync_err_d;
  logic                     sync_err_set;
  logic [31:0]              len_in;

  assign len_in = (bus.acc_len == '0) ? 32'd1 : bus.acc_len;

  always_comb begin
    state_d      = state_q;
    chan_cnt_d   = chan_cnt_q;
    spec_cnt_d   = spec_cnt_q;
    len_d        = len_q;
    acc_cnt_d    = acc_cnt_q;
    chan_idx_d   = chan_idx_q;
    valid_out_d  = 1'b0;
    new_acc_d    = 1'b0;
    acc_done_d   = 1'b0;
    sync_err_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.arm && !bus.stop) state_d = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.sync_in) begin
          state_d    = RUN;
          chan_cnt_d = '0;
          spec_cnt_d = '0;
          len_d      = len_in;
          acc_cnt_d  = '0;
        end
      end
      RUN, DRAIN: begin
        if (bus.din_valid) begin
          valid_out_d = 1'b1;
          chan_idx_d  = chan_cnt_q;
          new_acc_d   = (state_q == RUN) && (chan_cnt_q == '0) && (spec_cnt_q == '0);
          chan_cnt_d  = chan_cnt_q + CHANNEL_ADDR'(1);
          if (chan_cnt_q == CHAN_MAX) begin
            if (spec_cnt_q == len_q - 32'd1) begin
              acc_done_d = 1'b1;
              spec_cnt_d = '0;
              acc_cnt_d  = acc_cnt_q + ACC_CNT_WIDTH'(1);
              len_d      = len_in;
            end else begin
              spec_cnt_d = spec_cnt_q + 32'd1;
            end
          end
        end
        // Alignment is judged on the channel the next sample would carry,
        // so a sample coinciding with sync is counted before the resync.
        if (bus.sync_in && (chan_cnt_d != '0)) begin
          sync_err_set = 1'b1;
          chan_cnt_d   = '0;
          spec_cnt_d   = '0;
          len_d        = len_in;
        end
        // Draining ends once the counters sit at an accumulation boundary;
        // a stop before any sample of a fresh accumulation idles at once.
        if ((state_q == DRAIN) || bus.stop) begin
          state_d = ((chan_cnt_d == '0) && (spec_cnt_d == '0)) ? IDLE : DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Held through the final acc_done cycle so busy falls the cycle after it.
    busy_d     = (state_d != IDLE) || acc_done_d;
    sync_err_d = sync_err_set | (sync_err_q & ~bus.sync_err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      chan_cnt_q  <= '0;
      spec_cnt_q  <= '0;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      chan_idx_q  <= '0;
      valid_out_q <= 1'b0;
      new_acc_q   <= 1'b0;
      acc_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_cnt_q  <= chan_cnt_d;
      spec_cnt_q  <= spec_cnt_d;
      len_q       <= len_d;
      acc_cnt_q   <= acc_cnt_d;
      chan_idx_q  <= chan_idx_d;
      valid_out_q <= valid_out_d;
      new_acc_q   <= new_acc_d;
      acc_done_q  <= acc_done_d;
      busy_q      <= busy_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign bus.valid_out = valid_out_q;
  assign bus.new_acc   = new_acc_q;
  assign bus.chan_idx  = chan_idx_q;
  assign bus.acc_done  = acc_done_q;
  assign bus.acc_cnt   = acc_cnt_q;
  assign bus.busy      = busy_q;
  assign bus.sync_err  = sync_err_q;

`ifdef RFI_ACC_TIMESTAMP_EN
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] ts_q, ts_d;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    ts_d    = new_acc_d ? cycle_q : ts_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      ts_q    <= '0;
    end else begin
      cycle_q <= cycle_d;
      ts_q    <= ts_d;
    end
  end

  assign bus.acc_timestamp = ts_q;
`else
  assign bus.acc_timestamp = '0;
`endif
endmodule

// File: doc/rfi_acc_sequencer.md
Name: rfi_acc_sequencer

Overview:
- Run-control sequencer for the RFI power datapath: power stage, then vector accumulators, then resize and multiply.
- Arms on request and aligns to the spectrum sync.
- Counts channels and spectra per accumulation and emits the new_acc pulse that starts each accumulation.
- Latches acc_len only at accumulation boundaries, detects sync misalignment, and reports accumulation completion and count to software.

Parameters:
- CHANNEL_ADDR, 9, log2 of channels per spectrum.
- ACC_CNT_WIDTH, 32, width of completed-accumulation counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  pulse; start sequencing at next sync
- stop  in  1  pulse; finish current accumulation, then idle
- acc_len  in  32  spectra per accumulation; 0 treated as 1
- sync_in  in  1  pulse one cycle before channel 0 of a spectrum
- din_valid  in  1  one channel sample present
- valid_out  out  1  din_valid delayed 1 cycle, gated by RUN
- new_acc  out  1  high with valid_out of channel 0, spectrum 0 of each accumulation
- chan_idx  out  CHANNEL_ADDR  channel index aligned to valid_out
- acc_done  out  1  high with valid_out of last channel of last spectrum
- acc_cnt  out  ACC_CNT_WIDTH  completed accumulations since arm, wraps
- busy  out  1  high in WAIT_SYNC, RUN, DRAIN
- sync_err  out  1  sticky misalignment flag
- sync_err_clr  in  1  pulse; clears sync_err
- acc_timestamp  out  32  see Optional Feature

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- All outputs registered. Latency: din_valid to valid_out, new_acc, chan_idx and acc_done is exactly 1 cycle.
- IDLE:
  - valid_out, new_acc and acc_done held 0.
  - arm → WAIT_SYNC. If arm and stop are asserted in the same cycle, stay IDLE (stop wins).
- WAIT_SYNC:
  - din_valid ignored.
  - sync_in → RUN: chan_cnt=0, spec_cnt=0, acc_len latched (len_q = max(acc_len,1)), acc_cnt=0, first=1.
  - stop → IDLE.
- RUN, per din_valid:
  - Emit chan_idx=chan_cnt.
  - new_acc=1 when chan_cnt==0 and spec_cnt==0.
  - chan_cnt increments and wraps at 2**CHANNEL_ADDR-1.
  - On wrap, spec_cnt increments.
  - When spec_cnt==len_q-1 and chan_cnt is at its maximum:
    - acc_done=1, acc_cnt+1 (wraps), spec_cnt=0.
    - len_q reloaded from acc_len. A mid-accumulation acc_len change therefore never affects the running accumulation.
- stop in RUN:
  - Registers a pending flag; go to DRAIN.
  - DRAIN behaves as RUN, but at acc_done goes to IDLE instead of starting a new accumulation. No new_acc is emitted after stop.
  - arm during DRAIN is ignored.
- sync_in in RUN or DRAIN:
  - If chan_cnt==0 (aligned): no action.
  - Otherwise:
    - sync_err=1.
    - chan_cnt=0, spec_cnt=0, len_q reloaded. The partial accumulation is abandoned with no acc_done.
    - The next channel 0 carries new_acc.
    - acc_cnt unchanged.
- sync_in and din_valid in the same cycle: the din_valid sample is processed with the pre-sync counters, then the resync applies.
- Sync error flags:
  - sync_err_clr clears sync_err.
  - A simultaneous set and clear leaves sync_err set.
- din_valid gaps: counters hold. There is no timeout.
- Reset asserted mid-operation: immediate return to IDLE; all outputs cleared asynchronously.
- busy=1 from the cycle after arm until the cycle after the final acc_done in DRAIN.

Optional Feature:
- Macro RFI_ACC_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter, reset to 0, wraps.
  - Its value is captured into acc_timestamp on the same edge that asserts new_acc.
  - acc_timestamp holds until the next new_acc.
- Undefined: acc_timestamp is constant 0; no counter is synthesised.

Test Plan:
- CHANNEL_ADDR=2, acc_len=3; arm, then sync, then 24 continuous valids:
  - new_acc at valid_out indices 0 and 12.
  - acc_done at indices 11 and 23.
  - acc_cnt=2.
  - chan_idx cycles 0,1,2,3.
- acc_len changed 3→1 during the first accumulation: the first acc_done still occurs after 12 samples, then acc_done every 4 samples. acc_len=0 behaves identically to 1.
- sync_in asserted when chan_cnt=2 in RUN:
  - sync_err=1; no acc_done for the partial accumulation.
  - new_acc on the next valid; acc_cnt unchanged.
  - sync_err_clr returns sync_err to 0.
- stop asserted mid-accumulation (acc_len=2):
  - Current accumulation completes with acc_done.
  - busy drops the following cycle; no further new_acc.
  - Later valids produce valid_out=0.
- arm and stop asserted together in IDLE: stays IDLE; busy=0. A valid stream without arm produces no output.
- rst_n pulsed low mid-RUN: all outputs 0 immediately; after release, state is IDLE. With RFI_ACC_TIMESTAMP_EN, acc_timestamp increments by 12 cycles between consecutive new_acc for continuous input at acc_len=3.
